// File: rtl/mult_scheduler.sv
// mult_scheduler
// Shares one sequential shift-and-add unsigned multiplier between two
// requesters. A round-robin arbiter picks a winner in IDLE, its operands are
// latched, the multiply runs one partial product per cycle for WIDTH cycles,
// and the product is returned with a done pulse to the owner. When TX_EN is
// set, the result is then handed to a UART through a start/busy handshake.
//
// Ports
//   CLK            system clock, rising edge
//   rst            asynchronous active-low reset
//   req0, req1     operation requests
//   a0, b0         requester 0 multiplier / multiplicand
//   a1, b1         requester 1 multiplier / multiplicand
//   gnt0, gnt1     one-cycle accept pulse (operands latched on that edge)
//   done0, done1   one-cycle completion pulse to the owning requester
//   product        last completed result, held until the next completion
//   busy           high whenever the sequencer is not idle
//   tx_start       one-cycle start pulse to the UART
//   tx_busy        UART busy, blocks a new start while high
//   tx_data        copy of product for the UART
module mult_scheduler #(
   parameter int WIDTH = 4,
   parameter bit TX_EN = 1'b1
) (
   input  logic                 CLK,
   input  logic                 rst,
   input  logic                 req0,
   input  logic                 req1,
   input  logic [WIDTH-1:0]     a0,
   input  logic [WIDTH-1:0]     b0,
   input  logic [WIDTH-1:0]     a1,
   input  logic [WIDTH-1:0]     b1,
   output logic                 gnt0,
   output logic                 gnt1,
   output logic                 done0,
   output logic                 done1,
   output logic [2*WIDTH-1:0]   product,
   output logic                 busy,
   output logic                 tx_start,
   input  logic                 tx_busy,
   output logic [2*WIDTH-1:0]   tx_data
);

   localparam int PW = 2 * WIDTH;
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      SEND = 2'd2
   } state_t;

   state_t           state_r;
   logic             ptr_r;      // requester favoured on contention
   logic             owner_r;    // requester whose operation is in flight
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic [PW-1:0]    acc_r;
   logic [CW-1:0]    cnt_r;

   logic             pick1_s;
   logic [PW-1:0]    addend_s;
   logic [PW-1:0]    acc_next_s;

   // Arbitration: a lone request wins outright, contention follows the pointer.
   always_comb begin
      pick1_s = 1'b0;
      if (req0 && req1) begin
         pick1_s = ptr_r;
      end else if (req1) begin
         pick1_s = 1'b1;
      end else begin
         pick1_s = 1'b0;
      end
   end

   // Partial product for the current multiplier bit, zero-extended so the
   // shifted multiplicand never loses bits.
   always_comb begin
      addend_s = {PW{1'b0}};
      if (a_r[cnt_r]) begin
         addend_s = {{WIDTH{1'b0}}, b_r} << cnt_r;
      end else begin
         addend_s = {PW{1'b0}};
      end
      acc_next_s = acc_r + addend_s;
   end

   // Sequencer: arbitration, multiply iterations, result hand-off.
   always_ff @(posedge CLK or negedge rst) begin
      if (!rst) begin
         state_r  <= IDLE;
         ptr_r    <= 1'b0;
         owner_r  <= 1'b0;
         a_r      <= {WIDTH{1'b0}};
         b_r      <= {WIDTH{1'b0}};
         acc_r    <= {PW{1'b0}};
         cnt_r    <= {CW{1'b0}};
         product  <= {PW{1'b0}};
         gnt0     <= 1'b0;
         gnt1     <= 1'b0;
         done0    <= 1'b0;
         done1    <= 1'b0;
         tx_start <= 1'b0;
         busy     <= 1'b0;
      end else begin
         // pulses default low so none can last more than one cycle
         gnt0     <= 1'b0;
         gnt1     <= 1'b0;
         done0    <= 1'b0;
         done1    <= 1'b0;
         tx_start <= 1'b0;
         case (state_r)
            IDLE: begin
               if (req0 || req1) begin
                  owner_r <= pick1_s;
                  ptr_r   <= ~pick1_s;
                  a_r     <= pick1_s ? a1 : a0;
                  b_r     <= pick1_s ? b1 : b0;
                  acc_r   <= {PW{1'b0}};
                  cnt_r   <= {CW{1'b0}};
                  gnt0    <= ~pick1_s;
                  gnt1    <= pick1_s;
                  busy    <= 1'b1;
                  state_r <= MUL;
               end else begin
                  busy    <= 1'b0;
               end
            end
            MUL: begin
               acc_r <= acc_next_s;
               cnt_r <= cnt_r + CW'(1);
               if (cnt_r == CNT_LAST) begin
                  product <= acc_next_s;
                  done0   <= ~owner_r;
                  done1   <= owner_r;
                  if (TX_EN) begin
                     state_r <= SEND;
                     busy    <= 1'b1;
                  end else begin
                     state_r <= IDLE;
                     busy    <= 1'b0;
                  end
               end else begin
                  busy <= 1'b1;
               end
            end
            SEND: begin
               if (!tx_busy) begin
                  tx_start <= 1'b1;
                  state_r  <= IDLE;
                  busy     <= 1'b0;
               end else begin
                  busy     <= 1'b1;
               end
            end
            default: begin
               state_r <= IDLE;
               busy    <= 1'b0;
            end
         endcase
      end
   end

   assign tx_data = product;

endmodule

// File: tb/tb_mult_scheduler.sv
// Self-checking bench for mult_scheduler. A transaction-level model tracks
// pending requests, the round-robin pointer and expected products (a*b), and
// checks grant, done and tx handshake timing cycle by cycle.
module tb_mult_scheduler;

   localparam int W  = 4;
   localparam int PW = 2 * W;

   logic          CLK = 1'b0;
   logic          rst;
   logic          req0, req1, tx_busy;
   logic [W-1:0]  a0, b0, a1, b1;
   logic          gnt0, gnt1, done0, done1, busy, tx_start;
   logic [PW-1:0] product, tx_data;

   // second instance with the UART path disabled
   logic          req0z;
   logic [W-1:0]  a0z, b0z;
   logic          gnt0z, gnt1z, done0z, done1z, busyz, tx_startz;
   logic [PW-1:0] productz, tx_dataz;

   mult_scheduler #(.WIDTH(W), .TX_EN(1'b1)) u_dut (
      .CLK(CLK), .rst(rst), .req0(req0), .req1(req1),
      .a0(a0), .b0(b0), .a1(a1), .b1(b1),
      .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
      .product(product), .busy(busy), .tx_start(tx_start),
      .tx_busy(tx_busy), .tx_data(tx_data));

   mult_scheduler #(.WIDTH(W), .TX_EN(1'b0)) u_dut_notx (
      .CLK(CLK), .rst(rst), .req0(req0z), .req1(1'b0),
      .a0(a0z), .b0(b0z), .a1(4'd0), .b1(4'd0),
      .gnt0(gnt0z), .gnt1(gnt1z), .done0(done0z), .done1(done1z),
      .product(productz), .busy(busyz), .tx_start(tx_startz),
      .tx_busy(1'b0), .tx_data(tx_dataz));

   always #5 CLK = ~CLK;

   int checks   = 0;
   int failures = 0;

   // model state
   bit           exp_ptr;
   bit           pend0, pend1;
   logic [W-1:0] op_a [2];
   logic [W-1:0] op_b [2];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic drive_reqs();
      req0 = pend0;
      req1 = pend1;
      a0 = op_a[0]; b0 = op_b[0];
      a1 = op_a[1]; b1 = op_b[1];
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ctl"}, {gnt0, gnt1, done0, done1, tx_start, busy}, 32'd0);
      check({tag, "_product"}, product, 32'd0);
   endtask

   // Asynchronous reset pulse placed between clock edges.
   task automatic pulse_reset();
      #2 rst = 1'b0;
      #1 check_reset_outputs("rst_async");
      step();
      check_reset_outputs("rst_hold");
      #2 rst = 1'b1;
      exp_ptr = 1'b0;
      pend0 = 1'b0;
      pend1 = 1'b0;
      tx_busy = 1'b0;
      drive_reqs();
   endtask

   // One full transaction starting from IDLE: grant, WIDTH iterations,
   // done, then SEND held for 'hold' cycles of tx_busy.
   task automatic serve(input int hold);
      int            w;
      logic [PW-1:0] prod;
      drive_reqs();
      step();
      if (pend0 && pend1) w = int'(exp_ptr);
      else if (pend1)     w = 1;
      else                w = 0;
      check("gnt0", gnt0, 32'(w == 0));
      check("gnt1", gnt1, 32'(w == 1));
      check("busy_grant", busy, 32'd1);
      check("tx_start_single", tx_start, 32'd0);
      exp_ptr = (w == 0);
      prod = PW'(op_a[w]) * PW'(op_b[w]);
      if (w == 0) pend0 = 1'b0; else pend1 = 1'b0;
      drive_reqs();
      for (int k = 1; k < W; k++) begin
         step();
         check("no_early_pulse", {done0, done1, gnt0, gnt1}, 32'd0);
      end
      step();
      check("done0", done0, 32'(w == 0));
      check("done1", done1, 32'(w == 1));
      check("product", product, 32'(prod));
      check("busy_done", busy, 32'd1);
      tx_busy = (hold > 0);
      for (int k = 0; k < hold; k++) begin
         step();
         check("bp_tx_start", tx_start, 32'd0);
         check("bp_busy", busy, 32'd1);
         check("bp_no_gnt", {gnt0, gnt1, done0, done1}, 32'd0);
      end
      tx_busy = 1'b0;
      step();
      check("tx_start", tx_start, 32'd1);
      check("tx_data", tx_data, 32'(prod));
      check("busy_idle", busy, 32'd0);
      check("product_held", product, 32'(prod));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

   initial begin
      rst = 1'b0; tx_busy = 1'b0;
      req0z = 1'b0; a0z = '0; b0z = '0;
      exp_ptr = 1'b0; pend0 = 1'b0; pend1 = 1'b0;
      op_a[0] = '0; op_b[0] = '0; op_a[1] = '0; op_b[1] = '0;
      drive_reqs();
      #1 check_reset_outputs("rst_init");
      step();
      step();
      #2 rst = 1'b1;

      // single request
      pend0 = 1'b1; op_a[0] = 4'd7; op_b[0] = 4'd14;
      serve(0);

      // contention and alternation
      pulse_reset();
      pend0 = 1'b1; op_a[0] = 4'd15; op_b[0] = 4'd15;
      pend1 = 1'b1; op_a[1] = 4'd3;  op_b[1] = 4'd5;
      serve(0);
      serve(0);
      pend0 = 1'b1; pend1 = 1'b1;
      serve(0);
      serve(0);

      // transmitter back-pressure with a competing request pending
      pend0 = 1'b1; op_a[0] = 4'd5; op_b[0] = 4'd6;
      pend1 = 1'b1; op_a[1] = 4'd2; op_b[1] = 4'd7;
      serve(10);
      serve(0);

      // mid-multiply reset
      pend0 = 1'b1; op_a[0] = 4'd9; op_b[0] = 4'd9;
      drive_reqs();
      step();
      check("mid_gnt0", gnt0, 32'd1);
      pend0 = 1'b0;
      drive_reqs();
      step();
      pulse_reset();
      for (int k = 0; k < W + 2; k++) begin
         step();
         check("mid_no_done", {done0, done1, tx_start}, 32'd0);
      end
      check("mid_product", product, 32'd0);
      pend1 = 1'b1; op_a[1] = 4'd2; op_b[1] = 4'd3;
      serve(0);

      // zero operand and throughput on the instance without UART path
      a0z = 4'd0; b0z = 4'd9; req0z = 1'b1;
      step();
      check("z_gnt0", gnt0z, 32'd1);
      req0z = 1'b0;
      for (int k = 1; k < W; k++) begin
         step();
         check("z_no_done", done0z, 32'd0);
      end
      step();
      check("z_done0", done0z, 32'd1);
      check("z_product", productz, 32'd0);
      check("z_busy", busyz, 32'd0);
      a0z = 4'd3; b0z = 4'd5; req0z = 1'b1;
      step();
      check("z_gnt_a", gnt0z, 32'd1);
      for (int k = 1; k <= W + 1; k++) begin
         step();
         check("z_gnt_period", gnt0z, 32'(k == W + 1));
         check("z_tx_start", tx_startz, 32'd0);
         if (k == W) begin
            check("z_done_period", done0z, 32'd1);
            check("z_product2", productz, 32'd15);
         end
      end
      req0z = 1'b0;

      // randomized traffic
      for (int it = 0; it < 40; it++) begin
         if (!pend0 && ($urandom_range(0, 1) == 1)) begin
            pend0 = 1'b1; op_a[0] = W'($urandom); op_b[0] = W'($urandom);
         end
         if (!pend1 && ($urandom_range(0, 1) == 1)) begin
            pend1 = 1'b1; op_a[1] = W'($urandom); op_b[1] = W'($urandom);
         end
         if (!pend0 && !pend1) begin
            pend0 = 1'b1; op_a[0] = W'($urandom); op_b[0] = W'($urandom);
         end
         serve(int'($urandom_range(0, 3)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
